// File: rtl/bus_io_port_if.sv
// Processor memory-bus and TX/RX byte-stream signal bundle for bus_io_port.
// The slave modport is the responder's view; the master modport is the CPU/stream side.
interface bus_io_port_if;
  logic [15:0] ADDR_IN;
  logic [7:0]  DATA_IN;
  logic        WE_bar;
  logic        OE_bar;
  logic [7:0]  DATA_OUT;
  logic        DATA_OE_bar;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;

  modport slave (
    input  ADDR_IN, DATA_IN, WE_bar, OE_bar, TX_READY, RX_DATA, RX_VALID,
    output DATA_OUT, DATA_OE_bar, TX_DATA, TX_VALID, RX_READY
  );

  modport master (
    output ADDR_IN, DATA_IN, WE_bar, OE_bar, TX_READY, RX_DATA, RX_VALID,
    input  DATA_OUT, DATA_OE_bar, TX_DATA, TX_VALID, RX_READY
  );
endinterface

// File: rtl/bus_io_port.sv
// Memory-mapped byte I/O responder: bus writes feed a TX FIFO drained by a valid/ready
// stream, and a valid/ready stream fills an RX FIFO that bus reads of DATA pop.
module bus_io_port #(
  parameter int          DELAY_RISE = 0,
  parameter int          DELAY_FALL = 0,
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int unsigned TX_DEPTH   = 4,
  parameter int unsigned RX_DEPTH   = 4
) (
  input  logic         CLK,
  input  logic         RST,
  bus_io_port_if.slave bus
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_PW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_PW = RX_AW + 1;

  // Output delays are a simulation-only notion; only their sanity is checked here.
  if (BASE_ADDR[1:0] != 2'b00 || TX_DEPTH < 2 || RX_DEPTH < 2 ||
      (TX_DEPTH & (TX_DEPTH - 1)) != 0 || (RX_DEPTH & (RX_DEPTH - 1)) != 0 ||
      DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
    $error("bus_io_port: illegal parameter combination");
  end

  logic [TX_PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RX_PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic             err_q, err_d;
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [7:0]       rx_mem_q [RX_DEPTH];

  logic       hit, wr, rd;
  logic [1:0] off;
  logic       data_wr, data_rd, ctrl_wr;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_flush, rx_flush, err_clr, err_set;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0] rdata;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                    (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                    (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);

  // Address decode; a write strobe overrides a simultaneous read strobe.
  always_comb begin
    hit     = (bus.ADDR_IN[15:2] == BASE_ADDR[15:2]);
    off     = bus.ADDR_IN[1:0];
    wr      = hit & ~bus.WE_bar;
    rd      = hit & bus.WE_bar & ~bus.OE_bar;
    data_wr = wr & (off == 2'd0);
    data_rd = rd & (off == 2'd0);
    ctrl_wr = wr & (off == 2'd2);
  end

  // FIFO pointer and sticky error next state; a flush discards same-edge traffic.
  always_comb begin
    tx_flush = ctrl_wr & bus.DATA_IN[1];
    rx_flush = ctrl_wr & bus.DATA_IN[2];
    err_clr  = ctrl_wr & bus.DATA_IN[0];
    tx_push  = data_wr & ~tx_full & ~tx_flush;
    tx_pop   = ~tx_empty & bus.TX_READY & ~tx_flush;
    rx_push  = bus.RX_VALID & ~rx_full & ~RST & ~rx_flush;
    rx_pop   = data_rd & ~rx_empty & ~rx_flush;
    err_set  = (data_wr & tx_full & ~tx_flush) | (data_rd & rx_empty & ~rx_flush);

    tx_wr_d = tx_wr_q;
    tx_rd_d = tx_rd_q;
    rx_wr_d = rx_wr_q;
    rx_rd_d = rx_rd_q;
    if (tx_flush) tx_rd_d = tx_wr_q;
    if (tx_push)  tx_wr_d = tx_wr_q + TX_PW'(1);
    if (tx_pop)   tx_rd_d = tx_rd_q + TX_PW'(1);
    if (rx_flush) rx_rd_d = rx_wr_q;
    if (rx_push)  rx_wr_d = rx_wr_q + RX_PW'(1);
    if (rx_pop)   rx_rd_d = rx_rd_q + RX_PW'(1);
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      err_q   <= 1'b0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      err_q   <= err_d;
    end
  end

  // Storage keeps its contents across reset; only the pointers are cleared.
  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= bus.DATA_IN;
    if (rx_push) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= bus.RX_DATA;
  end

  always_comb begin
    rdata = 8'h00;
    if (rd) begin
      case (off)
        2'd0:    if (!rx_empty) rdata = rx_mem_q[rx_rd_q[RX_AW-1:0]];
        2'd1:    rdata = {3'b000, err_q, tx_full, tx_empty, rx_full, ~rx_empty};
        default: rdata = 8'h00;
      endcase
    end
  end

  assign bus.DATA_OUT    = rdata;
  assign bus.DATA_OE_bar = ~rd;
  assign bus.TX_DATA     = tx_mem_q[tx_rd_q[TX_AW-1:0]];
  assign bus.TX_VALID    = ~tx_empty;
  assign bus.RX_READY    = ~rx_full & ~RST;

endmodule

// File: tb/tb_bus_io_port.sv
// Bench for bus_io_port: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based model of the port.
module tb_bus_io_port;

  logic clk;
  logic rst;
  bus_io_port_if bus ();

  bus_io_port #(.BASE_ADDR(16'hFF00), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_err;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  din;
    logic        we_n;
    logic        oe_n;
    logic        txr;
    logic [7:0]  rxd;
    logic        rxv;
    logic [7:0]  dout;
    logic        doe_n;
    logic        txv;
    logic [7:0]  txd;
    logic        rxr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [15:0] a, logic [7:0] d, logic w, logic o, logic tr,
                              logic [7:0] rd, logic rv, logic [7:0] edo, logic eoe,
                              logic etv, logic [7:0] etd, logic err_rdy);
    vec_t v;
    v.addr = a; v.din = d; v.we_n = w; v.oe_n = o; v.txr = tr; v.rxd = rd; v.rxv = rv;
    v.dout = edo; v.doe_n = eoe; v.txv = etv; v.txd = etd; v.rxr = err_rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [15:0] a, input logic [7:0] d, input logic w,
                        input logic o, input logic tr, input logic [7:0] rd, input logic rv);
    bus.ADDR_IN  = a;
    bus.DATA_IN  = d;
    bus.WE_bar   = w;
    bus.OE_bar   = o;
    bus.TX_READY = tr;
    bus.RX_DATA  = rd;
    bus.RX_VALID = rv;
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_err = 1'b0;
  endtask

  // Expected outputs derived from queue contents and the current bus cycle.
  task automatic model_check();
    bit         hit, rd;
    int         off;
    logic [7:0] exp_do;
    hit = (bus.ADDR_IN >= 16'hFF00) && (bus.ADDR_IN <= 16'hFF03);
    off = int'(bus.ADDR_IN) - 32'hFF00;
    rd  = hit && bus.WE_bar && !bus.OE_bar;
    exp_do = 8'h00;
    if (rd && off == 0 && rx_q.size() != 0) exp_do = rx_q[0];
    if (rd && off == 1)
      exp_do = {3'b000, m_err, tx_q.size() == 4, tx_q.size() == 0,
                rx_q.size() == 4, rx_q.size() != 0};
    chk("model DATA_OUT", bus.DATA_OUT, exp_do);
    chk("model DATA_OE_bar", 8'(bus.DATA_OE_bar), 8'(!rd));
    chk("model TX_VALID", 8'(bus.TX_VALID), 8'(tx_q.size() != 0));
    if (tx_q.size() != 0) chk("model TX_DATA", bus.TX_DATA, tx_q[0]);
    chk("model RX_READY", 8'(bus.RX_READY), 8'(rx_q.size() < 4));
  endtask

  task automatic model_update();
    bit hit, wr, rd, tx_full, rx_empty, rx_full, set_e;
    int off;
    hit = (bus.ADDR_IN >= 16'hFF00) && (bus.ADDR_IN <= 16'hFF03);
    off = int'(bus.ADDR_IN) - 32'hFF00;
    wr  = hit && !bus.WE_bar;
    rd  = hit && bus.WE_bar && !bus.OE_bar;
    tx_full  = (tx_q.size() == 4);
    rx_empty = (rx_q.size() == 0);
    rx_full  = (rx_q.size() == 4);
    set_e = 1'b0;
    if (wr && off == 2 && bus.DATA_IN[1]) tx_q.delete();
    else begin
      if (tx_q.size() != 0 && bus.TX_READY) void'(tx_q.pop_front());
      if (wr && off == 0) begin
        if (tx_full) set_e = 1'b1;
        else tx_q.push_back(bus.DATA_IN);
      end
    end
    if (wr && off == 2 && bus.DATA_IN[2]) rx_q.delete();
    else begin
      if (rd && off == 0) begin
        if (rx_empty) set_e = 1'b1;
        else void'(rx_q.pop_front());
      end
      if (bus.RX_VALID && !rx_full) rx_q.push_back(bus.RX_DATA);
    end
    if (set_e) m_err = 1'b1;
    else if (wr && off == 2 && bus.DATA_IN[0]) m_err = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    set_in(16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #3;
    chk("reset TX_VALID", 8'(bus.TX_VALID), 8'h00);
    chk("reset RX_READY", 8'(bus.RX_READY), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // addr, din, we_n, oe_n, txr, rxd, rxv | dout, doe_n, txv, txd, rxr
    tbl.push_back(mk(16'hFF01, 8'h00, 1, 0, 0, 8'h00, 0, 8'h04, 0, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF00, 8'hA5, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF00, 8'h3C, 0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'hA5, 1));
    tbl.push_back(mk(16'h0000, 8'h00, 1, 1, 1, 8'h00, 0, 8'h00, 1, 1, 8'hA5, 1));
    tbl.push_back(mk(16'h0000, 8'h00, 1, 1, 1, 8'h00, 0, 8'h00, 1, 1, 8'h3C, 1));
    tbl.push_back(mk(16'h0000, 8'h00, 1, 1, 1, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1));
    tbl.push_back(mk(16'h0000, 8'h00, 1, 1, 0, 8'h11, 1, 8'h00, 1, 0, 8'h00, 1));
    tbl.push_back(mk(16'h0000, 8'h00, 1, 1, 0, 8'h22, 1, 8'h00, 1, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF01, 8'h00, 1, 0, 0, 8'h00, 0, 8'h05, 0, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h11, 0, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h22, 0, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF01, 8'h00, 1, 0, 0, 8'h00, 0, 8'h14, 0, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF02, 8'h01, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF03, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFEFF, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF04, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF03, 8'h55, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFEFF, 8'h77, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF00, 8'h9A, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1));
    tbl.push_back(mk(16'hFF01, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h9A, 1));
    tbl.push_back(mk(16'h0000, 8'h00, 1, 1, 1, 8'h00, 0, 8'h00, 1, 1, 8'h9A, 1));
    tbl.push_back(mk(16'hFF01, 8'h00, 1, 0, 0, 8'h00, 0, 8'h04, 0, 0, 8'h00, 1));

    foreach (tbl[i]) begin
      set_in(tbl[i].addr, tbl[i].din, tbl[i].we_n, tbl[i].oe_n, tbl[i].txr,
             tbl[i].rxd, tbl[i].rxv);
      #1;
      chk($sformatf("tbl[%0d] DATA_OUT", i), bus.DATA_OUT, tbl[i].dout);
      chk($sformatf("tbl[%0d] DATA_OE_bar", i), 8'(bus.DATA_OE_bar), 8'(tbl[i].doe_n));
      chk($sformatf("tbl[%0d] TX_VALID", i), 8'(bus.TX_VALID), 8'(tbl[i].txv));
      if (tbl[i].txv) chk($sformatf("tbl[%0d] TX_DATA", i), bus.TX_DATA, tbl[i].txd);
      chk($sformatf("tbl[%0d] RX_READY", i), 8'(bus.RX_READY), 8'(tbl[i].rxr));
      step();
    end

    // TX overflow: fifth byte dropped, err set, first four drain in order.
    for (int i = 1; i <= 5; i++) begin
      set_in(16'hFF00, 8'(i), 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      step();
    end
    set_in(16'hFF01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1 chk("ovf STATUS", bus.DATA_OUT, 8'h18);
    step();
    for (int i = 1; i <= 4; i++) begin
      set_in(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
      #1 chk("ovf drain TX_DATA", bus.TX_DATA, 8'(i));
      step();
    end
    idle();
    #1 chk("ovf drained TX_VALID", 8'(bus.TX_VALID), 8'h00);
    step();
    set_in(16'hFF02, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    set_in(16'hFF01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1 chk("err cleared STATUS", bus.DATA_OUT, 8'h04);
    step();

    // RX full, source holds fifth byte, RX flush reopens the FIFO.
    for (int i = 0; i < 4; i++) begin
      set_in(16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 8'hB1 + 8'(i), 1'b1);
      step();
    end
    set_in(16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 8'hB5, 1'b1);
    #1 chk("rx full RX_READY", 8'(bus.RX_READY), 8'h00);
    step();
    set_in(16'hFF02, 8'h04, 1'b0, 1'b1, 1'b0, 8'hB5, 1'b1);
    #1 chk("rx flush RX_READY before", 8'(bus.RX_READY), 8'h00);
    step();
    set_in(16'hFF01, 8'h00, 1'b1, 1'b0, 1'b0, 8'hB5, 1'b1);
    #1 chk("rx flushed RX_READY", 8'(bus.RX_READY), 8'h01);
    chk("rx flushed STATUS", bus.DATA_OUT, 8'h04);
    step();
    set_in(16'hFF00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1 chk("rx fifth byte", bus.DATA_OUT, 8'hB5);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = 16'hFF00;
        4:          a = 16'hFF01;
        5:          a = 16'hFF02;
        6:          a = 16'hFF03;
        7:          a = 16'hFEFF;
        8:          a = 16'hFF04;
        default:    a = 16'($urandom);
      endcase
      set_in(a, 8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      step();
    end

    // Asynchronous reset in the middle of traffic.
    set_in(16'hFF00, 8'hC7, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    set_in(16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1);
    #1 chk("pre-reset TX_VALID", 8'(bus.TX_VALID), 8'h01);
    #1 rst = 1'b1;
    #1;
    chk("mid reset TX_VALID", 8'(bus.TX_VALID), 8'h00);
    chk("mid reset RX_READY", 8'(bus.RX_READY), 8'h00);
    @(posedge clk);
    #1 chk("held reset RX_READY", 8'(bus.RX_READY), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_in(16'hFF01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1 chk("post reset STATUS", bus.DATA_OUT, 8'h04);
    chk("post reset RX_READY", 8'(bus.RX_READY), 8'h01);
    step();
    set_in(16'hFF00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    set_in(16'hFF01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1 chk("post reset underflow STATUS", bus.DATA_OUT, 8'h14);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
